// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op encodings, FSM states,
// error causes and the request legality helpers.
package mips_mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ILLEGAL,
    ERR_ALIGN,
    ERR_RANGE
  } err_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
      default:                                                  op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op[1:0])
      SIZE_HALF: misaligned = lane[0];
      SIZE_WORD: misaligned = (lane != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts and extends a byte/half for loads and
// splices store data into the read word for SB/SH read-modify-write.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = word[31:24];
    case (lane)
      2'd0: byte_sel = word[31:24];
      2'd1: byte_sel = word[23:16];
      2'd2: byte_sel = word[15:8];
      2'd3: byte_sel = word[7:0];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[15:0] : word[31:16];

    load_data = word;
    case (op[1:0])
      SIZE_BYTE: load_data = op[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = op[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:   load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (op[1:0])
      SIZE_BYTE: begin
        case (lane)
          2'd0: merged = {wdata[7:0], word[23:0]};
          2'd1: merged = {word[31:24], wdata[7:0], word[15:0]};
          2'd2: merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd3: merged = {word[31:8], wdata[7:0]};
          default: merged = word;
        endcase
      end
      SIZE_HALF: merged = lane[1] ? {word[31:16], wdata} : {wdata, word[15:0]};
      default:   merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-only data_memory: one request at a
// time, sub-word loads via lane extraction, sub-word stores via read-modify-write.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [31:0]       mem_read_data
);

  state_t      state;
  err_t        err_cause;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_ready = (state == ST_IDLE);

  always_comb begin
    err_cause = ERR_NONE;
    if (!op_legal(req_op))                    err_cause = ERR_ILLEGAL;
    else if (misaligned(req_op, req_addr[1:0])) err_cause = ERR_ALIGN;
    else if (req_addr[31:ADDR_W+2] != '0)       err_cause = ERR_RANGE;
  end

  mem_lane_align u_align (
    .op        (op_q[2:0]),
    .lane      (lane_q),
    .word      (mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            if (err_cause != ERR_NONE) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= req_addr[ADDR_W+1:2];
              if (req_op == OP_SW) begin
                state          <= ST_WR;
                mem_memwrite   <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                // loads and SB/SH both start with a read of the containing word
                state       <= ST_RD;
                mem_memread <= 1'b1;
              end
            end
          end
        end
        ST_RD: begin
          mem_memread <= 1'b0;
          if (op_q[3]) begin
            state          <= ST_WR;
            mem_memwrite   <= 1'b1;
            mem_write_data <= merged;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        ST_WR: begin
          mem_memwrite <= 1'b0;
          state        <= ST_RESP;
          resp_valid   <= 1'b1;
          resp_err     <= 1'b0;
          resp_rdata   <= '0;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: word memory model on negedge, scoreboard of
// expected responses pushed at issue and popped when resp_valid is seen.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [12:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_read_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] mem [0:8191];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [12:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        prev_resp = 1'b0;

  mem_access_unit #(.ADDR_W(13)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // data_memory model plus response scoreboard, all on the negedge
  always @(negedge clk) begin
    if (mem_memread && mem_memwrite) both_cnt++;
    if (mem_memread) begin
      mem_read_data = mem[mem_address];
      rd_cnt++;
    end
    if (mem_memwrite) begin
      mem[mem_address] = mem_write_data;
      last_wr_addr = mem_address;
      last_wr_data = mem_write_data;
      wr_cnt++;
    end
    if (req_valid && req_ready && rst_n) acc_q.push_back(cyc);
    if (prev_resp) check("resp_pulse_width", {31'd0, resp_valid}, 32'd0);
    if (resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", 32'(cyc - a), 32'(e.lat));
      end
    end
    prev_resp = resp_valid;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input bit hold, output int acc);
    bit taken;
    exp_t e;
    taken = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      if (req_ready) begin
        taken = 1'b1;
        acc = cyc;
      end
    end
    check("accept", {31'd0, taken}, 32'd1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int acc;
    issue(op, addr, wdata, exp_rdata, exp_err, exp_lat, 1'b0, acc);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0, wr0, acc1, acc2;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem_read_data = '0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    check("rst_mem_address", {19'd0, mem_address}, 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
    rst_n = 1'b1;

    // reset pulse in the RD cycle of an LW abandons the access
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rd_before_reset", {31'd0, mem_memread}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_memread_drop", {31'd0, mem_memread}, 32'd0);
    check("async_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("post_reset_ready", {31'd0, req_ready}, 32'd1);
      check("post_reset_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // SW then LW
    rd0 = rd_cnt; wr0 = wr_cnt;
    req(4'b1010, 32'h10, 32'h12345678, 32'h0, 1'b0, 2);
    check("sw_addr", {19'd0, last_wr_addr}, 32'd4);
    check("sw_data", last_wr_data, 32'h12345678);
    check("sw_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
    check("sw_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
    req(4'b0010, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);

    // SB read-modify-write and byte loads
    rd0 = rd_cnt; wr0 = wr_cnt;
    req(4'b1000, 32'h11, 32'h000000AB, 32'h0, 1'b0, 3);
    check("sb_data", last_wr_data, 32'h12AB5678);
    check("sb_rd_cycles", 32'(rd_cnt - rd0), 32'd1);
    check("sb_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
    req(4'b0000, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    req(4'b0100, 32'h11, 32'h0, 32'h000000AB, 1'b0, 2);
    req(4'b0000, 32'h10, 32'h0, 32'h00000012, 1'b0, 2);

    // SH at offset 2 and half loads
    req(4'b1001, 32'h12, 32'hFFFF8001, 32'h0, 1'b0, 3);
    check("sh_data", last_wr_data, 32'h12AB8001);
    req(4'b0001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2);
    req(4'b0101, 32'h12, 32'h0, 32'h00008001, 1'b0, 2);
    req(4'b0001, 32'h10, 32'h0, 32'h000012AB, 1'b0, 2);

    // last byte lane
    req(4'b1000, 32'h13, 32'h000000FF, 32'h0, 1'b0, 3);
    check("sb_lane3_data", last_wr_data, 32'h12AB80FF);
    req(4'b0000, 32'h13, 32'h0, 32'hFFFFFFFF, 1'b0, 2);

    // highest legal word address
    req(4'b1010, 32'h7FFC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    check("top_addr", {19'd0, last_wr_addr}, 32'h1FFF);
    req(4'b0010, 32'h7FFC, 32'h0, 32'hCAFEF00D, 1'b0, 2);

    // error requests: no strobes, latency 1
    rd0 = rd_cnt; wr0 = wr_cnt;
    req(4'b0010, 32'h13, 32'h0, 32'h0, 1'b1, 1);
    req(4'b0001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    req(4'b0010, 32'h8000, 32'h0, 32'h0, 1'b1, 1);
    req(4'b0011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    req(4'b1010, 32'h12, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    check("err_rd_cycles", 32'(rd_cnt - rd0), 32'd0);
    check("err_wr_cycles", 32'(wr_cnt - wr0), 32'd0);
    req(4'b0010, 32'h10, 32'h0, 32'h12AB80FF, 1'b0, 2);

    // req_valid held across two SWs
    issue(4'b1010, 32'h20, 32'h11111111, 32'h0, 1'b0, 2, 1'b1, acc1);
    issue(4'b1010, 32'h24, 32'h22222222, 32'h0, 1'b0, 2, 1'b0, acc2);
    drain();
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);
    req(4'b0010, 32'h20, 32'h0, 32'h11111111, 1'b0, 2);
    req(4'b0010, 32'h24, 32'h0, 32'h22222222, 1'b0, 2);

    check("never_both_strobes", 32'(both_cnt), 32'd0);
    check("idle_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
